noc_vchannel_arbiter: RTL and testbench

NOC_VCHANNEL_ARBITER -- requirements
Module: noc_vchannel_arbiter

---
 rtl/noc_vchannel_arbiter.sv | 124 ++++++++++++
 tb/tb_noc_vchannel_arbiter.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/noc_vchannel_arbiter.sv
// Packet-atomic virtual-channel arbiter onto a single NoC link.
// Round-robin IDLE grant by default; define OPTIMSOC_VCARB_PRIO_EN for strict priority (lowest index).
module noc_vchannel_arbiter #(
  parameter int FLIT_WIDTH = 32,
  parameter int CHANNELS   = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [CHANNELS*FLIT_WIDTH-1:0] in_flit,
  input  logic [CHANNELS-1:0]            in_last,
  input  logic [CHANNELS-1:0]            in_valid,
  output logic [CHANNELS-1:0]            in_ready,
  output logic [FLIT_WIDTH-1:0]          out_flit,
  output logic                           out_last,
  output logic                           out_valid,
  input  logic                           out_ready
);

  localparam int CW = $clog2(CHANNELS);

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   owner_q, owner_d;
  logic [CW-1:0]   pick;
  logic [CW-1:0]   grant;
  logic            any_valid;
  logic            grant_en;
  logic            xfer;
  logic [FLIT_WIDTH-1:0] flits [CHANNELS];

  always_comb begin
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      flits[i] = in_flit[i*FLIT_WIDTH +: FLIT_WIDTH];
    end
  end

  assign any_valid = |in_valid;

`ifdef OPTIMSOC_VCARB_PRIO_EN
  always_comb begin
    logic          found;
    logic [CW-1:0] sel;
    pick  = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      sel = CW'(i);
      if (!found && in_valid[sel]) begin
        found = 1'b1;
        pick  = sel;
      end
    end
  end
`else
  logic [CW-1:0] last_grant_q, last_grant_d;

  // Search order starts one past the previous winner and wraps modulo CHANNELS.
  always_comb begin
    logic          found;
    logic [CW-1:0] sel;
    int unsigned   idx;
    pick  = '0;
    found = 1'b0;
    for (int unsigned i = 1; i <= CHANNELS; i++) begin
      idx = (int'(last_grant_q) + i) % CHANNELS;
      sel = CW'(idx);
      if (!found && in_valid[sel]) begin
        found = 1'b1;
        pick  = sel;
      end
    end
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (state_q == IDLE && any_valid) last_grant_d = pick;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) last_grant_q <= CW'(CHANNELS - 1);
    else        last_grant_q <= last_grant_d;
  end
`endif

  // Outputs are gated by rst_n so the link is quiet during reset whatever the inputs do.
  always_comb begin
    grant     = (state_q == LOCKED) ? owner_q : pick;
    grant_en  = rst_n && ((state_q == LOCKED) || any_valid);
    out_valid = grant_en && in_valid[grant];
    out_flit  = out_valid ? flits[grant] : '0;
    out_last  = out_valid && in_last[grant];
    in_ready  = '0;
    if (grant_en) in_ready[grant] = out_ready;
    xfer      = out_valid && out_ready;
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    case (state_q)
      IDLE: begin
        if (any_valid && !(xfer && in_last[grant])) begin
          state_d = LOCKED;
          owner_d = grant;
        end
      end
      LOCKED: begin
        if (xfer && in_last[grant]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

endmodule

// File: tb/tb_noc_vchannel_arbiter.sv
// Directed self-checking bench for noc_vchannel_arbiter with four 16-bit channels.
module tb_noc_vchannel_arbiter;

  localparam int FW = 16;
  localparam int CH = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [CH*FW-1:0]  in_flit;
  logic [CH-1:0]     in_last;
  logic [CH-1:0]     in_valid;
  logic [CH-1:0]     in_ready;
  logic [FW-1:0]     out_flit;
  logic              out_last;
  logic              out_valid;
  logic              out_ready;

  int total  = 0;
  int passed = 0;
  int cnt  [CH];
  int plen [CH];

  noc_vchannel_arbiter #(.FLIT_WIDTH(FW), .CHANNELS(CH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_flit(in_flit), .in_last(in_last), .in_valid(in_valid), .in_ready(in_ready),
    .out_flit(out_flit), .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [FW-1:0] mk(input int c, input int i);
    return {4'(c), 12'(i)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic restart(input int p0, input int p1, input int p2, input int p3);
    plen = '{p0, p1, p2, p3};
    cnt  = '{0, 0, 0, 0};
  endtask

  // One cycle: producers present flit cnt[c]; e is the expected granted channel (-1 = no out_valid).
  task automatic cyc(input logic [CH-1:0] v, input logic rdy, input int e,
                     input logic [CH-1:0] eir, input string tag);
    for (int c = 0; c < CH; c++) begin
      in_flit[c*FW +: FW] = mk(c, cnt[c]);
      in_last[c]          = (cnt[c] % plen[c]) == plen[c] - 1;
    end
    in_valid  = v;
    out_ready = rdy;
    #1;
    chk({tag, ".valid"}, 32'(out_valid), 32'(e >= 0));
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(eir));
    if (e >= 0) begin
      chk({tag, ".flit"}, 32'(out_flit), 32'(mk(e, cnt[e])));
      chk({tag, ".last"}, 32'(out_last), 32'((cnt[e] % plen[e]) == plen[e] - 1));
      if (rdy) cnt[e]++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic reset_cycle(input string tag);
    rst_n     = 1'b0;
    in_valid  = '1;
    in_last   = '1;
    out_ready = 1'b1;
    #1;
    chk({tag, ".valid"}, 32'(out_valid), 32'(0));
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(0));
    chk({tag, ".flit"}, 32'(out_flit), 32'(0));
    chk({tag, ".last"}, 32'(out_last), 32'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; in_flit = '0; in_last = '0; in_valid = '0; out_ready = 1'b0;
    @(posedge clk); #1;
    reset_cycle("rst");

    // Idle: no requester, ready high, link must stay quiet.
    restart(1, 1, 1, 1);
    cyc(4'b0000, 1'b1, -1, 4'b0000, "idle");
    chk("idle.flit0", 32'(out_flit), 32'(0));

`ifdef OPTIMSOC_VCARB_PRIO_EN
    for (int k = 0; k < 4; k++) cyc(4'b0011, 1'b1, 0, 4'b0001, "prio_ch0");
    cyc(4'b0010, 1'b1, 1, 4'b0010, "prio_ch1");
    cyc(4'b0110, 1'b1, 1, 4'b0010, "prio_low");
    cyc(4'b0011, 1'b1, 0, 4'b0001, "prio_back");
    restart(2, 1, 1, 1);
    cyc(4'b0011, 1'b0, 0, 4'b0000, "prio_lock0");
    cyc(4'b0010, 1'b1, -1, 4'b0001, "prio_bubble");
    cyc(4'b0011, 1'b1, 0, 4'b0001, "prio_lock1");
`else
    // Two channels, 3-flit packets back to back: packets alternate, never interleave.
    restart(3, 3, 1, 1);
    for (int k = 0; k < 12; k++) begin
      if ((k / 3) % 2 == 0) cyc(4'b0011, 1'b1, 0, 4'b0001, "rr_pkt0");
      else                  cyc(4'b0011, 1'b1, 1, 4'b0010, "rr_pkt1");
    end

    // ch1 arrives mid ch0 packet with a stalling downstream.
    restart(3, 1, 1, 1);
    cyc(4'b0001, 1'b1, 0, 4'b0001, "stall_f0");
    cyc(4'b0011, 1'b0, 0, 4'b0000, "stall_f1_hold");
    cyc(4'b0011, 1'b1, 0, 4'b0001, "stall_f1_go");
    cyc(4'b0011, 1'b0, 0, 4'b0000, "stall_f2_hold");
    cyc(4'b0011, 1'b1, 0, 4'b0001, "stall_f2_go");
    cyc(4'b0010, 1'b1, 1, 4'b0010, "stall_ch1");

    // Bubble inside ch0 packet while ch1 waits.
    restart(2, 1, 1, 1);
    cyc(4'b0011, 1'b1, 0, 4'b0001, "bub_f0");
    cyc(4'b0010, 1'b1, -1, 4'b0001, "bub_gap0");
    cyc(4'b0010, 1'b1, -1, 4'b0001, "bub_gap1");
    cyc(4'b0011, 1'b1, 0, 4'b0001, "bub_f1");
    cyc(4'b0010, 1'b1, 1, 4'b0010, "bub_ch1");

    // Reset in the middle of a ch1 packet; ch0 wins afterwards.
    restart(1, 4, 1, 1);
    cyc(4'b0010, 1'b1, 1, 4'b0010, "mid_f0");
    cyc(4'b0011, 1'b1, 1, 4'b0010, "mid_f1");
    reset_cycle("mid_rst");
    cyc(4'b0011, 1'b1, 0, 4'b0001, "post_rst_ch0");
    cyc(4'b0010, 1'b1, 1, 4'b0010, "post_rst_ch1a");
    cyc(4'b0010, 1'b1, 1, 4'b0010, "post_rst_ch1b");

    // All four channels, single-flit packets, continuous.
    reset_cycle("rst4");
    restart(1, 1, 1, 1);
    for (int k = 0; k < 8; k++) begin
      logic [CH-1:0] m;
      m = '0;
      m[k % 4] = 1'b1;
      cyc(4'b1111, 1'b1, k % 4, m, "rr4");
    end

    // Ready with nothing to grant must not move the pointer (last winner was ch3).
    cyc(4'b0000, 1'b1, -1, 4'b0000, "noop0");
    cyc(4'b0000, 1'b1, -1, 4'b0000, "noop1");
    cyc(4'b0110, 1'b1, 1, 4'b0010, "noop_next");
    cyc(4'b0110, 1'b1, 2, 4'b0100, "noop_next2");
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1);
  end

endmodule
